lsu_ram_master: RTL and testbench

- Initiator-side load/store unit that converts RV32I core memory requests into the word-organised, byte-enabled RAM port (read req/addr/data, write enable/byte enable/addr/data).
- Handles byte/half/word alignment, write-data lane steering, load sign/zero extension and misalignment detection.
- Returns one response per request through a valid/ready handshake.
- Sits between the execute stage and the data RAM.

---
 rtl/lsu_pkg.sv | 16 +
 rtl/lsu_align.sv | 67 ++++++
 rtl/lsu_ram_master.sv | 133 +++++++++++++
 tb/tb_lsu_ram_master.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width encodings and FSM states.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic for the load/store unit: store lane steering, byte enables,
// load extraction/extension and misaligned or illegal request detection.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  byte_enable,
    output logic [31:0] wdata_steered,
    output logic [31:0] rdata_ext,
    output logic        err
);

    logic [31:0] rdata_shifted;
    logic        misaligned;
    logic        illegal;

    always_comb begin
        byte_enable   = 4'b0000;
        wdata_steered = 32'h0;
        rdata_ext     = 32'h0;
        misaligned    = 1'b0;
        illegal       = 1'b0;
        rdata_shifted = rdata >> {addr_lo, 3'b000};

        case (funct3)
            F3_B: begin
                byte_enable   = 4'b0001 << addr_lo;
                wdata_steered = {4{wdata[7:0]}};
                rdata_ext     = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            end
            F3_BU: begin
                rdata_ext     = {24'h0, rdata_shifted[7:0]};
            end
            F3_H: begin
                byte_enable   = 4'b0011 << addr_lo;
                wdata_steered = {2{wdata[15:0]}};
                rdata_ext     = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
                misaligned    = addr_lo[0];
            end
            F3_HU: begin
                rdata_ext     = {16'h0, rdata_shifted[15:0]};
                misaligned    = addr_lo[0];
            end
            F3_W: begin
                byte_enable   = 4'b1111;
                wdata_steered = wdata;
                rdata_ext     = rdata_shifted;
                misaligned    = (addr_lo != 2'b00);
            end
            default: begin
                illegal       = 1'b1;
            end
        endcase

        // Unsigned widths only exist for loads.
        if (we && funct3[2]) begin
            illegal = 1'b1;
        end

        err = misaligned | illegal;
    end

endmodule

// File: rtl/lsu_ram_master.sv
// Load/store unit bridging RV32I core memory requests to a word-organised,
// byte-enabled RAM port with a one-request-at-a-time valid/ready response.
module lsu_ram_master
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 31,
    parameter int DATA_WIDTH = 31
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [2:0]            i_req_funct3,
    input  logic [ADDR_WIDTH:0]   i_req_addr,
    input  logic [DATA_WIDTH:0]   i_req_wdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH:0]   o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic                  o_read_req,
    output logic [ADDR_WIDTH:0]   o_read_addr,
    input  logic [DATA_WIDTH:0]   i_read_data,
    output logic                  o_write_enable,
    output logic [3:0]            o_byte_enable,
    output logic [ADDR_WIDTH:0]   o_write_addr,
    output logic [DATA_WIDTH:0]   o_write_data
);

    lsu_state_t          state;
    logic                lat_we;
    logic [2:0]          lat_funct3;
    logic [1:0]          lat_addr_lo;
    logic                write_enable_q;

    logic                sel_we;
    logic [2:0]          sel_funct3;
    logic [1:0]          sel_addr_lo;
    logic [3:0]          align_be;
    logic [31:0]         align_wdata;
    logic [31:0]         align_rdata;
    logic                align_err;
    logic [ADDR_WIDTH:0] req_word_addr;

    // The aligner sees the incoming request while idle and the latched one afterwards.
    assign sel_we        = (state == IDLE) ? i_req_we             : lat_we;
    assign sel_funct3    = (state == IDLE) ? i_req_funct3         : lat_funct3;
    assign sel_addr_lo   = (state == IDLE) ? i_req_addr[1:0]      : lat_addr_lo;
    assign req_word_addr = {2'b00, i_req_addr[ADDR_WIDTH:2]};

    assign o_req_ready    = (state == IDLE);
    // A store caught by reset in its access cycle must not land in the RAM.
    assign o_write_enable = write_enable_q & ~rst;

    lsu_align u_align (
        .we            (sel_we),
        .funct3        (sel_funct3),
        .addr_lo       (sel_addr_lo),
        .wdata         (i_req_wdata),
        .rdata         (i_read_data),
        .byte_enable   (align_be),
        .wdata_steered (align_wdata),
        .rdata_ext     (align_rdata),
        .err           (align_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            lat_we         <= 1'b0;
            lat_funct3     <= 3'b000;
            lat_addr_lo    <= 2'b00;
            o_rsp_valid    <= 1'b0;
            o_rsp_rdata    <= '0;
            o_rsp_err      <= 1'b0;
            o_read_req     <= 1'b0;
            write_enable_q <= 1'b0;
            o_byte_enable  <= 4'b0000;
            o_read_addr    <= '0;
            o_write_addr   <= '0;
            o_write_data   <= '0;
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        lat_we      <= i_req_we;
                        lat_funct3  <= i_req_funct3;
                        lat_addr_lo <= i_req_addr[1:0];
                        if (align_err) begin
                            state       <= RESP;
                            o_rsp_valid <= 1'b1;
                            o_rsp_err   <= 1'b1;
                            o_rsp_rdata <= '0;
                        end else begin
                            state          <= ACCESS;
                            o_read_req     <= ~i_req_we;
                            write_enable_q <= i_req_we;
                            o_byte_enable  <= i_req_we ? align_be : 4'b0000;
                            o_write_data   <= i_req_we ? align_wdata : '0;
                            o_read_addr    <= req_word_addr;
                            o_write_addr   <= req_word_addr;
                        end
                    end
                end
                ACCESS: begin
                    state          <= RESP;
                    o_read_req     <= 1'b0;
                    write_enable_q <= 1'b0;
                    o_byte_enable  <= 4'b0000;
                    o_write_data   <= '0;
                    o_read_addr    <= '0;
                    o_write_addr   <= '0;
                    o_rsp_valid    <= 1'b1;
                    o_rsp_err      <= 1'b0;
                    o_rsp_rdata    <= lat_we ? '0 : align_rdata;
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        state       <= IDLE;
                        o_rsp_valid <= 1'b0;
                        o_rsp_err   <= 1'b0;
                        o_rsp_rdata <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ram_master.sv
// Directed bench for lsu_ram_master with a small byte-enabled RAM attached.
module tb_lsu_ram_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [2:0]  i_req_funct3;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic        o_read_req;
    logic [31:0] o_read_addr;
    logic [31:0] i_read_data;
    logic        o_write_enable;
    logic [3:0]  o_byte_enable;
    logic [31:0] o_write_addr;
    logic [31:0] o_write_data;

    logic [31:0] mem [0:15];
    logic        mem_clear;
    int          n_checks = 0;
    int          n_fail = 0;
    int          wr_events = 0;
    int          strobe_cycles = 0;
    int          wr_before;
    int          strobe_before;

    always #5 clk = ~clk;

    lsu_ram_master dut (
        .clk            (clk),
        .rst            (rst),
        .clk_en         (clk_en),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_we       (i_req_we),
        .i_req_funct3   (i_req_funct3),
        .i_req_addr     (i_req_addr),
        .i_req_wdata    (i_req_wdata),
        .o_rsp_valid    (o_rsp_valid),
        .i_rsp_ready    (i_rsp_ready),
        .o_rsp_rdata    (o_rsp_rdata),
        .o_rsp_err      (o_rsp_err),
        .o_read_req     (o_read_req),
        .o_read_addr    (o_read_addr),
        .i_read_data    (i_read_data),
        .o_write_enable (o_write_enable),
        .o_byte_enable  (o_byte_enable),
        .o_write_addr   (o_write_addr),
        .o_write_data   (o_write_data)
    );

    // RAM: combinational read, byte-enabled write gated by the same clock enable.
    assign i_read_data = mem[o_read_addr[3:0]];

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int w = 0; w < 16; w++) mem[w] <= 32'h0;
        end else if (clk_en && o_write_enable) begin
            wr_events++;
            for (int b = 0; b < 4; b++)
                if (o_byte_enable[b]) mem[o_write_addr[3:0]][8*b +: 8] <= o_write_data[8*b +: 8];
        end
    end

    always @(negedge clk) begin
        if (o_read_req || o_write_enable) strobe_cycles++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Presents one request for a single accepting edge, then lands #1 after it.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        i_req_valid  = 1'b1;
        i_req_we     = we;
        i_req_funct3 = f3;
        i_req_addr   = addr;
        i_req_wdata  = wdata;
        @(posedge clk); #1;
        i_req_valid  = 1'b0;
    endtask

    task automatic finishResponse(input string tag);
        i_rsp_ready = 1'b1;
        @(posedge clk); #1;
        i_rsp_ready = 1'b0;
        checkOutput({tag, " valid dropped"}, o_rsp_valid, 1'b0);
        checkOutput({tag, " ready back"}, o_req_ready, 1'b1);
    endtask

    task automatic doAccess(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                            input logic [31:0] exp_rd);
        applyStimulus(we, f3, addr, wdata);
        checkOutput({tag, " read_req"}, o_read_req, !we);
        checkOutput({tag, " write_enable"}, o_write_enable, we);
        checkOutput({tag, " byte_enable"}, o_byte_enable, exp_be);
        checkOutput({tag, " write_data"}, o_write_data, exp_wd);
        checkOutput({tag, " word addr"}, we ? o_write_addr : o_read_addr, {2'b00, addr[31:2]});
        checkOutput({tag, " no early rsp"}, o_rsp_valid, 1'b0);
        @(posedge clk); #1;
        checkOutput({tag, " rsp_valid"}, o_rsp_valid, 1'b1);
        checkOutput({tag, " rsp_err"}, o_rsp_err, 1'b0);
        checkOutput({tag, " rdata"}, o_rsp_rdata, exp_rd);
        checkOutput({tag, " strobes off"}, {o_read_req, o_write_enable, o_byte_enable}, 6'b0);
        finishResponse(tag);
    endtask

    task automatic doError(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] addr);
        strobe_before = strobe_cycles;
        applyStimulus(we, f3, addr, 32'hFFFF_FFFF);
        checkOutput({tag, " rsp_valid"}, o_rsp_valid, 1'b1);
        checkOutput({tag, " rsp_err"}, o_rsp_err, 1'b1);
        checkOutput({tag, " rdata zero"}, o_rsp_rdata, 32'h0);
        checkOutput({tag, " ready low"}, o_req_ready, 1'b0);
        finishResponse(tag);
        checkOutput({tag, " no strobe"}, strobe_cycles, strobe_before);
    endtask

    initial begin
        rst          = 1'b1;
        mem_clear    = 1'b1;
        clk_en       = 1'b1;
        i_req_valid  = 1'b0;
        i_req_we     = 1'b0;
        i_req_funct3 = 3'b000;
        i_req_addr   = 32'h0;
        i_req_wdata  = 32'h0;
        i_rsp_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        mem_clear = 1'b0;

        checkOutput("reset ready", o_req_ready, 1'b1);
        checkOutput("reset rsp", {o_rsp_valid, o_rsp_err}, 2'b00);
        checkOutput("reset rdata", o_rsp_rdata, 32'h0);
        checkOutput("reset strobes", {o_read_req, o_write_enable, o_byte_enable}, 6'b0);
        checkOutput("reset wdata", o_write_data, 32'h0);
        checkOutput("reset waddr", o_write_addr, 32'h0);

        doAccess("SW 0x10",  1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 32'h0);
        doAccess("SB 0x13",  1'b1, 3'b000, 32'h13, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5, 32'h0);
        doAccess("LW 0x10",  1'b0, 3'b010, 32'h10, 32'h0, 4'b0000, 32'h0, 32'hA5AD_BEEF);
        doAccess("SW seed",  1'b1, 3'b010, 32'h10, 32'h80F0_7F81, 4'b1111, 32'h80F0_7F81, 32'h0);
        doAccess("LB 0x10",  1'b0, 3'b000, 32'h10, 32'h0, 4'b0000, 32'h0, 32'hFFFF_FF81);
        doAccess("LBU 0x10", 1'b0, 3'b100, 32'h10, 32'h0, 4'b0000, 32'h0, 32'h0000_0081);
        doAccess("LH 0x12",  1'b0, 3'b001, 32'h12, 32'h0, 4'b0000, 32'h0, 32'hFFFF_80F0);
        doAccess("LHU 0x12", 1'b0, 3'b101, 32'h12, 32'h0, 4'b0000, 32'h0, 32'h0000_80F0);
        doAccess("LB 0x11",  1'b0, 3'b000, 32'h11, 32'h0, 4'b0000, 32'h0, 32'h0000_007F);
        doAccess("SH 0x12",  1'b1, 3'b001, 32'h12, 32'hABCD_1234, 4'b1100, 32'h1234_1234, 32'h0);
        doAccess("LHU hi",   1'b0, 3'b101, 32'h12, 32'h0, 4'b0000, 32'h0, 32'h0000_1234);

        doError("LW 0x12 misaligned", 1'b0, 3'b010, 32'h12);
        doError("SH 0x11 misaligned", 1'b1, 3'b001, 32'h11);
        doError("load f3 011",        1'b0, 3'b011, 32'h10);
        doError("store f3 100",       1'b1, 3'b100, 32'h10);

        // Response held off: output must stay put and a new request must be ignored.
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0);
        @(posedge clk); #1;
        wr_before    = wr_events;
        i_req_valid  = 1'b1;
        i_req_we     = 1'b1;
        i_req_funct3 = 3'b010;
        i_req_addr   = 32'h14;
        i_req_wdata  = 32'h5555_5555;
        for (int c = 0; c < 5; c++) begin
            checkOutput("stall valid", o_rsp_valid, 1'b1);
            checkOutput("stall rdata", o_rsp_rdata, 32'h1234_7F81);
            checkOutput("stall ready", o_req_ready, 1'b0);
            @(posedge clk); #1;
        end
        i_req_valid = 1'b0;
        finishResponse("stall");
        checkOutput("stall no write", wr_events, wr_before);
        checkOutput("stall mem5", mem[5], 32'h0);

        // Clock enable dropped for three cycles during the access cycle of a load.
        applyStimulus(1'b0, 3'b000, 32'h13, 32'h0);
        clk_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checkOutput("frozen read_req", o_read_req, 1'b1);
            checkOutput("frozen no rsp", o_rsp_valid, 1'b0);
        end
        clk_en = 1'b1;
        @(posedge clk); #1;
        checkOutput("clk_en rsp_valid", o_rsp_valid, 1'b1);
        checkOutput("clk_en rdata", o_rsp_rdata, 32'h0000_0012);
        finishResponse("clk_en");

        // Reset landing in the access cycle of a store.
        wr_before = wr_events;
        applyStimulus(1'b1, 3'b010, 32'h20, 32'hCAFE_F00D);
        checkOutput("pre-reset we", o_write_enable, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("reset gates we", o_write_enable, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("abort no write", wr_events, wr_before);
        checkOutput("abort mem8", mem[8], 32'h0);
        checkOutput("abort strobes", {o_read_req, o_write_enable, o_byte_enable}, 6'b0);
        checkOutput("abort outputs", {o_write_addr | o_write_data | o_read_addr | o_rsp_rdata}, 32'h0);
        checkOutput("abort rsp", {o_rsp_valid, o_rsp_err, o_req_ready}, 3'b001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
